superscalar_hazard_unit: RTL and testbench

- Parametrised successor to the dual-issue forwarding logic: N-lane operand forwarding with cross-lane priority.
- Adds load-use stall detection and intra-bundle dependency hold.
- Adds a sequential scoreboard that tracks in-flight long-latency (mul/div) destinations and stalls Decode until each result is available.
- Sits between the Decode/Execute pipeline registers and the Execute operand muxes of the superscalar core.

---
 rtl/superscalar_hazard_unit.sv | 131 +++++++++++++
 tb/tb_superscalar_hazard_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/superscalar_hazard_unit.sv
// N-lane hazard unit: operand forwarding with cross-lane priority, load-use and
// long-latency scoreboard stalls, and intra-bundle dependency hold.
module superscalar_hazard_unit #(
  parameter int LANES    = 2,
  parameter int REG_BITS = 5,
  parameter int NUM_REGS = 32,
  parameter int LAT_MAX  = 15,
  parameter int CNT_W    = $clog2(LAT_MAX + 1),
  parameter int SEL_W    = $clog2(2 * LANES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*REG_BITS-1:0] rs_d,
  input  logic [LANES*REG_BITS-1:0] rt_d,
  input  logic [LANES*REG_BITS-1:0] rd_d,
  input  logic [LANES-1:0]          regwrite_d,
  input  logic [LANES*REG_BITS-1:0] rs_e,
  input  logic [LANES*REG_BITS-1:0] rt_e,
  input  logic [LANES*REG_BITS-1:0] rd_e,
  input  logic [LANES-1:0]          memread_e,
  input  logic [LANES-1:0]          long_issue_e,
  input  logic [LANES*CNT_W-1:0]    long_lat_e,
  input  logic [LANES*REG_BITS-1:0] wr_m,
  input  logic [LANES*REG_BITS-1:0] wr_w,
  input  logic [LANES-1:0]          regwrite_m,
  input  logic [LANES-1:0]          regwrite_w,
  output logic [LANES*SEL_W-1:0]    fwd_a,
  output logic [LANES*SEL_W-1:0]    fwd_b,
  output logic                      stall_d,
  output logic [LANES-1:0]          lane_hold_d,
  output logic [NUM_REGS-1:0]       sb_busy
);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_d;
  logic [LANES-1:0]               hold_raw;

  function automatic logic [CNT_W-1:0] clamp_lat(input logic [CNT_W-1:0] lat);
    if (int'(lat) > LAT_MAX) return CNT_W'(LAT_MAX);
    return lat;
  endfunction

  // Writeback is scanned first so a Memory match overrides it; ascending lane
  // order lets the youngest lane of each stage win.
  function automatic logic [SEL_W-1:0] fwd_sel(
    input logic [REG_BITS-1:0]       src,
    input logic [LANES*REG_BITS-1:0] wm,
    input logic [LANES-1:0]          rwm,
    input logic [LANES*REG_BITS-1:0] ww,
    input logic [LANES-1:0]          rww
  );
    logic [SEL_W-1:0] sel;
    sel = '0;
    if (src != '0) begin
      for (int k = 0; k < LANES; k++)
        if (rww[k] && ww[k*REG_BITS +: REG_BITS] == src) sel = SEL_W'(1 + LANES + k);
      for (int k = 0; k < LANES; k++)
        if (rwm[k] && wm[k*REG_BITS +: REG_BITS] == src) sel = SEL_W'(1 + k);
    end
    return sel;
  endfunction

  function automatic logic src_hazard(
    input logic [REG_BITS-1:0]       src,
    input logic [NUM_REGS-1:0]       busy,
    input logic [LANES-1:0]          mr,
    input logic [LANES*REG_BITS-1:0] rde
  );
    logic hit;
    hit = 1'b0;
    if (src != '0) begin
      if (busy[src]) hit = 1'b1;
      for (int j = 0; j < LANES; j++)
        if (mr[j] && rde[j*REG_BITS +: REG_BITS] == src) hit = 1'b1;
    end
    return hit;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Issue overrides the decrement; later (younger) lanes overwrite earlier ones.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
    for (int k = 0; k < LANES; k++) begin
      if (long_issue_e[k] && rd_e[k*REG_BITS +: REG_BITS] != '0 &&
          long_lat_e[k*CNT_W +: CNT_W] != '0)
        cnt_d[rd_e[k*REG_BITS +: REG_BITS]] = clamp_lat(long_lat_e[k*CNT_W +: CNT_W]);
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) sb_busy[r] = |cnt_q[r];
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      fwd_a[k*SEL_W +: SEL_W] = fwd_sel(rs_e[k*REG_BITS +: REG_BITS], wr_m, regwrite_m, wr_w, regwrite_w);
      fwd_b[k*SEL_W +: SEL_W] = fwd_sel(rt_e[k*REG_BITS +: REG_BITS], wr_m, regwrite_m, wr_w, regwrite_w);
    end
  end

  always_comb begin
    stall_d = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (src_hazard(rs_d[k*REG_BITS +: REG_BITS], sb_busy, memread_e, rd_e) ||
          src_hazard(rt_d[k*REG_BITS +: REG_BITS], sb_busy, memread_e, rd_e))
        stall_d = 1'b1;
    end
  end

  // Once a lane is held, every younger lane in the bundle is held with it.
  always_comb begin
    hold_raw = '0;
    for (int j = 1; j < LANES; j++) begin
      hold_raw[j] = hold_raw[j-1];
      for (int i = 0; i < j; i++) begin
        if (regwrite_d[i] && rd_d[i*REG_BITS +: REG_BITS] != '0 &&
            (rs_d[j*REG_BITS +: REG_BITS] == rd_d[i*REG_BITS +: REG_BITS] ||
             rt_d[j*REG_BITS +: REG_BITS] == rd_d[i*REG_BITS +: REG_BITS]))
          hold_raw[j] = 1'b1;
      end
    end
  end

  assign lane_hold_d = stall_d ? '0 : hold_raw;

endmodule

// File: tb/tb_superscalar_hazard_unit.sv
// Self-checking bench for superscalar_hazard_unit (3 lanes, LAT_MAX 12 so that
// latency clamping is reachable) against a ready-time reference model.
module tb_superscalar_hazard_unit;
  localparam int LANES    = 3;
  localparam int REG_BITS = 5;
  localparam int NUM_REGS = 32;
  localparam int LAT_MAX  = 12;
  localparam int CNT_W    = $clog2(LAT_MAX + 1);
  localparam int SEL_W    = $clog2(2 * LANES + 1);
  localparam int RB       = REG_BITS;

  logic                   clk, rst;
  logic [LANES*RB-1:0]    rs_d, rt_d, rd_d, rs_e, rt_e, rd_e, wr_m, wr_w;
  logic [LANES-1:0]       regwrite_d, memread_e, long_issue_e, regwrite_m, regwrite_w;
  logic [LANES*CNT_W-1:0] long_lat_e;
  logic [LANES*SEL_W-1:0] fwd_a, fwd_b;
  logic                   stall_d;
  logic [LANES-1:0]       lane_hold_d;
  logic [NUM_REGS-1:0]    sb_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int expire [NUM_REGS];

  superscalar_hazard_unit #(
    .LANES(LANES), .REG_BITS(REG_BITS), .NUM_REGS(NUM_REGS), .LAT_MAX(LAT_MAX),
    .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .memread_e(memread_e),
    .long_issue_e(long_issue_e), .long_lat_e(long_lat_e), .wr_m(wr_m), .wr_w(wr_w),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_d(stall_d), .lane_hold_d(lane_hold_d), .sb_busy(sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [RB-1:0] lr(input logic [LANES*RB-1:0] v, input int k);
    return v[k*RB +: RB];
  endfunction

  function automatic bit m_busy(input int r);
    return (r != 0) && (cyc < expire[r]);
  endfunction

  function automatic logic [NUM_REGS-1:0] m_busy_vec();
    logic [NUM_REGS-1:0] v;
    for (int r = 0; r < NUM_REGS; r++) v[r] = m_busy(r);
    return v;
  endfunction

  function automatic int m_fwd(input logic [RB-1:0] src);
    if (src == 0) return 0;
    for (int k = LANES - 1; k >= 0; k--)
      if (regwrite_m[k] && lr(wr_m, k) == src) return 1 + k;
    for (int k = LANES - 1; k >= 0; k--)
      if (regwrite_w[k] && lr(wr_w, k) == src) return 1 + LANES + k;
    return 0;
  endfunction

  function automatic logic [LANES*SEL_W-1:0] m_fwd_vec(input logic [LANES*RB-1:0] srcs);
    logic [LANES*SEL_W-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*SEL_W +: SEL_W] = SEL_W'(m_fwd(lr(srcs, k)));
    return v;
  endfunction

  function automatic bit m_src_stall(input logic [RB-1:0] src);
    if (src == 0) return 1'b0;
    if (m_busy(int'(src))) return 1'b1;
    for (int j = 0; j < LANES; j++)
      if (memread_e[j] && lr(rd_e, j) == src) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    for (int k = 0; k < LANES; k++)
      if (m_src_stall(lr(rs_d, k)) || m_src_stall(lr(rt_d, k))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [LANES-1:0] m_hold();
    logic [LANES-1:0] v;
    int first;
    first = -1;
    v = '0;
    if (m_stall()) return v;
    for (int j = 1; j < LANES; j++)
      for (int i = 0; i < j; i++)
        if (first < 0 && regwrite_d[i] && lr(rd_d, i) != 0 &&
            (lr(rs_d, j) == lr(rd_d, i) || lr(rt_d, j) == lr(rd_d, i)))
          first = j;
    if (first > 0)
      for (int j = first; j < LANES; j++) v[j] = 1'b1;
    return v;
  endfunction

  // Advance one clock, recording each new long-op's ready cycle first.
  task automatic tick();
    int lat;
    if (!rst) begin
      for (int k = 0; k < LANES; k++) begin
        lat = int'(long_lat_e[k*CNT_W +: CNT_W]);
        if (long_issue_e[k] && lr(rd_e, k) != 0 && lat != 0)
          expire[lr(rd_e, k)] = cyc + 1 + ((lat > LAT_MAX) ? LAT_MAX : lat);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; rd_d = '0; regwrite_d = '0;
    rs_e = '0; rt_e = '0; rd_e = '0; memread_e = '0;
    long_issue_e = '0; long_lat_e = '0;
    wr_m = '0; wr_w = '0; regwrite_m = '0; regwrite_w = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) expire[r] = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    tick(); tick();
    checks++;
    if (fwd_a !== '0 || fwd_b !== '0) begin
      failures++; $display("FAIL reset_fwd got a=%h b=%h want 0", fwd_a, fwd_b);
    end
    checks++;
    if (stall_d !== 1'b0 || lane_hold_d !== '0) begin
      failures++; $display("FAIL reset_ctl got stall=%b hold=%b want 0", stall_d, lane_hold_d);
    end
    checks++;
    if (sb_busy !== '0) begin
      failures++; $display("FAIL reset_busy got %h want 0", sb_busy);
    end
    rst = 1'b0;
    long_issue_e[0] = 1'b1; rd_e[0 +: RB] = 5; long_lat_e[0 +: CNT_W] = 5;
    tick();
    clear_inputs();
    tick(); tick();
    checks++;
    if (sb_busy[5] !== m_busy(5) || sb_busy[5] !== 1'b1) begin
      failures++; $display("FAIL reset_precount busy5 got %b want 1", sb_busy[5]);
    end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (sb_busy !== m_busy_vec()) begin
      failures++; $display("FAIL reset_async busy got %h want %h", sb_busy, m_busy_vec());
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_forward_priority();
    clear_inputs();
    rs_e[0 +: RB] = 7;
    wr_m[0 +: RB] = 7; wr_m[RB +: RB] = 7; regwrite_m = 3'b011;
    wr_w[0 +: RB] = 7; regwrite_w = 3'b001;
    #1;
    checks++;
    if (fwd_a[0 +: SEL_W] !== 3'd2 || fwd_a !== m_fwd_vec(rs_e)) begin
      failures++; $display("FAIL fwd_m_lane1 got %h want %h", fwd_a, m_fwd_vec(rs_e));
    end
    regwrite_m = '0;
    #1;
    checks++;
    if (fwd_a[0 +: SEL_W] !== SEL_W'(1 + LANES) || fwd_a !== m_fwd_vec(rs_e)) begin
      failures++; $display("FAIL fwd_w_lane0 got %h want %h", fwd_a, m_fwd_vec(rs_e));
    end
    clear_inputs();
    regwrite_m = '1; regwrite_w = '1;
    #1;
    checks++;
    if (fwd_a !== '0 || fwd_b !== '0) begin
      failures++; $display("FAIL fwd_zero_src got a=%h b=%h want 0", fwd_a, fwd_b);
    end
    clear_inputs();
    rt_e[2*RB +: RB] = 11; wr_w[RB +: RB] = 11; wr_w[2*RB +: RB] = 11; regwrite_w = 3'b110;
    #1;
    checks++;
    if (fwd_b !== m_fwd_vec(rt_e) || fwd_b[2*SEL_W +: SEL_W] !== SEL_W'(1 + LANES + 2)) begin
      failures++; $display("FAIL fwd_w_youngest got %h want %h", fwd_b, m_fwd_vec(rt_e));
    end
  endtask

  task automatic test_scoreboard();
    int nbusy, nstall;
    clear_inputs();
    long_issue_e[1] = 1'b1; rd_e[RB +: RB] = 9; long_lat_e[CNT_W +: CNT_W] = 3;
    tick();
    clear_inputs();
    rs_d[0 +: RB] = 9;
    nbusy = 0; nstall = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (stall_d !== m_stall() || sb_busy !== m_busy_vec()) begin
        failures++; $display("FAIL sb_count cyc%0d got stall=%b busy=%h want stall=%b busy=%h",
                             i, stall_d, sb_busy, m_stall(), m_busy_vec());
      end
      if (sb_busy[9]) nbusy++;
      if (stall_d) nstall++;
      tick();
    end
    checks++;
    if (nbusy != 3 || nstall != 3) begin
      failures++; $display("FAIL sb_lat3 got busy=%0d stall=%0d cycles want 3", nbusy, nstall);
    end
  endtask

  task automatic test_sb_edges();
    int n;
    clear_inputs();
    long_issue_e = 3'b011; rd_e[0 +: RB] = 4; rd_e[RB +: RB] = 4;
    long_lat_e[0 +: CNT_W] = 2; long_lat_e[CNT_W +: CNT_W] = 5;
    tick();
    clear_inputs();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (sb_busy[4]) n++;
      tick();
    end
    checks++;
    if (n != 5) begin
      failures++; $display("FAIL sb_same_cycle got %0d busy cycles want 5", n);
    end
    long_issue_e[0] = 1'b1; rd_e[0 +: RB] = 4; long_lat_e[0 +: CNT_W] = 2;
    tick();
    clear_inputs();
    tick();
    long_issue_e[2] = 1'b1; rd_e[2*RB +: RB] = 4; long_lat_e[2*CNT_W +: CNT_W] = 2;
    tick();
    clear_inputs();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sb_busy !== m_busy_vec()) begin
        failures++; $display("FAIL sb_reload cyc%0d got %h want %h", i, sb_busy, m_busy_vec());
      end
      if (sb_busy[4]) n++;
      tick();
    end
    checks++;
    if (n != 2) begin
      failures++; $display("FAIL sb_reload_len got %0d want 2", n);
    end
    long_issue_e[0] = 1'b1; rd_e[0 +: RB] = 6; long_lat_e[0 +: CNT_W] = 0;
    tick();
    clear_inputs();
    checks++;
    if (sb_busy[6] !== 1'b0) begin
      failures++; $display("FAIL sb_lat0 got %b want 0", sb_busy[6]);
    end
    long_issue_e[1] = 1'b1; rd_e[RB +: RB] = 8; long_lat_e[CNT_W +: CNT_W] = 15;
    tick();
    clear_inputs();
    n = 0;
    for (int i = 0; i < 18; i++) begin
      if (sb_busy[8]) n++;
      tick();
    end
    checks++;
    if (n != LAT_MAX) begin
      failures++; $display("FAIL sb_clamp got %0d busy cycles want %0d", n, LAT_MAX);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    memread_e[0] = 1'b1; rd_e[0 +: RB] = 12;
    rt_d[RB +: RB] = 12; rd_d[0 +: RB] = 12; regwrite_d = 3'b001;
    #1;
    checks++;
    if (stall_d !== 1'b1 || lane_hold_d !== 3'b000) begin
      failures++; $display("FAIL load_use got stall=%b hold=%b want 1/000", stall_d, lane_hold_d);
    end
    rd_e[0 +: RB] = 0;
    #1;
    checks++;
    if (stall_d !== m_stall() || lane_hold_d !== m_hold() || stall_d !== 1'b0) begin
      failures++; $display("FAIL load_use_rd0 got stall=%b hold=%b want %b/%b",
                           stall_d, lane_hold_d, m_stall(), m_hold());
    end
  endtask

  task automatic test_bundle_hold();
    clear_inputs();
    rd_d[0 +: RB] = 3; regwrite_d = 3'b001; rs_d[RB +: RB] = 3;
    #1;
    checks++;
    if (lane_hold_d !== 3'b110) begin
      failures++; $display("FAIL hold_lane1 got %b want 110", lane_hold_d);
    end
    regwrite_d = '0;
    #1;
    checks++;
    if (lane_hold_d !== 3'b000) begin
      failures++; $display("FAIL hold_nowrite got %b want 000", lane_hold_d);
    end
    clear_inputs();
    rd_d[RB +: RB] = 4; regwrite_d = 3'b010; rt_d[2*RB +: RB] = 4;
    #1;
    checks++;
    if (lane_hold_d !== 3'b100 || lane_hold_d !== m_hold()) begin
      failures++; $display("FAIL hold_lane2 got %b want %b", lane_hold_d, m_hold());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < LANES; k++) begin
        rs_d[k*RB +: RB] = RB'($urandom_range(0, 7));
        rt_d[k*RB +: RB] = RB'($urandom_range(0, 7));
        rd_d[k*RB +: RB] = RB'($urandom_range(0, 7));
        rs_e[k*RB +: RB] = RB'($urandom_range(0, 7));
        rt_e[k*RB +: RB] = RB'($urandom_range(0, 7));
        rd_e[k*RB +: RB] = RB'($urandom_range(0, 7));
        wr_m[k*RB +: RB] = RB'($urandom_range(0, 7));
        wr_w[k*RB +: RB] = RB'($urandom_range(0, 7));
        long_lat_e[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 15));
        long_issue_e[k] = ($urandom_range(0, 3) == 0);
        memread_e[k]    = ($urandom_range(0, 4) == 0);
      end
      regwrite_d = LANES'($urandom); regwrite_m = LANES'($urandom); regwrite_w = LANES'($urandom);
      #1;
      checks++;
      if (fwd_a !== m_fwd_vec(rs_e) || fwd_b !== m_fwd_vec(rt_e)) begin
        failures++; $display("FAIL rnd_fwd it%0d got a=%h b=%h want a=%h b=%h",
                             i, fwd_a, fwd_b, m_fwd_vec(rs_e), m_fwd_vec(rt_e));
      end
      checks++;
      if (sb_busy !== m_busy_vec()) begin
        failures++; $display("FAIL rnd_busy it%0d got %h want %h", i, sb_busy, m_busy_vec());
      end
      checks++;
      if (stall_d !== m_stall() || lane_hold_d !== m_hold()) begin
        failures++; $display("FAIL rnd_ctl it%0d got stall=%b hold=%b want %b/%b",
                             i, stall_d, lane_hold_d, m_stall(), m_hold());
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_forward_priority();
    test_scoreboard();
    test_sb_edges();
    test_load_use();
    test_bundle_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
